// File: rtl/mult_pkg.sv
// Shared constants for the pipelined multiplier:
// operand mode encoding and legal pipeline-depth limits.
package mult_pkg;

    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } mode_e;

    localparam int PIPE_MIN  = 1;
    localparam int PIPE_MAX  = 8;
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/mult_pipe_stage.sv
// One pipeline register stage: valid bit plus data,
// advancing only when the pipeline-wide enable is high.
module mult_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         v_in,
    input  logic [W-1:0] d,
    output logic         v_q,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= 1'b0;
            q   <= '0;
        end else if (en) begin
            v_q <= v_in;
            q   <= d;
        end
    end

endmodule

// File: rtl/mult_pipelined_param.sv
// Pipelined signed/unsigned multiplier with valid/ready flow control;
// the whole pipe moves as one unit whenever the output can advance.
module mult_pipelined_param
    import mult_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PIPE_STAGES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    input  logic                    signed_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] out
);

    localparam int OW = 2 * DATA_WIDTH;
    localparam int XW = DATA_WIDTH + 1;

    logic                   adv;
    logic [XW-1:0]          a_x;
    logic [XW-1:0]          b_x;
    logic [PIPE_STAGES-1:0] vq;

    // Extended operands are true signed values, so one signed
    // multiply truncated to OW bits serves both modes exactly.
    function automatic logic [OW-1:0] mul(
        input logic [XW-1:0] x,
        input logic [XW-1:0] y
    );
        return OW'($signed(x)) * OW'($signed(y));
    endfunction

    assign a_x = {(signed_mode == MODE_SIGNED) && a[DATA_WIDTH-1], a};
    assign b_x = {(signed_mode == MODE_SIGNED) && b[DATA_WIDTH-1], b};

    assign out_valid = vq[PIPE_STAGES-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_st
        logic v_in;

        if (i == 0) begin : g_vin0
            assign v_in = in_valid;
        end else begin : g_vinn
            assign v_in = vq[i-1];
        end

        // With more than one stage, the first one holds the
        // extended operands and the multiply sits behind it.
        if (i == 0 && PIPE_STAGES > 1) begin : g_ops
            logic [2*XW-1:0] q;

            mult_pipe_stage #(.W(2 * XW)) u_stage (
                .clk  (clk),
                .rst  (rst),
                .en   (adv),
                .v_in (v_in),
                .d    ({a_x, b_x}),
                .v_q  (vq[i]),
                .q    (q)
            );
        end else begin : g_prod
            logic [OW-1:0] d;
            logic [OW-1:0] q;

            if (i == 0) begin : g_d0
                assign d = mul(a_x, b_x);
            end else if (i == 1) begin : g_d1
                assign d = mul(g_st[0].g_ops.q[2*XW-1:XW],
                               g_st[0].g_ops.q[XW-1:0]);
            end else begin : g_dn
                assign d = g_st[i-1].g_prod.q;
            end

            mult_pipe_stage #(.W(OW)) u_stage (
                .clk  (clk),
                .rst  (rst),
                .en   (adv),
                .v_in (v_in),
                .d    (d),
                .v_q  (vq[i]),
                .q    (q)
            );
        end
    end

    assign out = g_st[PIPE_STAGES-1].g_prod.q;

endmodule

// File: tb/tb_mult_pipelined_param.sv
// Directed and scoreboard bench for the pipelined multiplier,
// covering the default 8-bit/3-stage build and a 16-bit/1-stage build.
module tb_mult_pipelined_param;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] p;
    } vec8_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [31:0] p;
    } vec16_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, sm, out_valid, out_ready;
    logic [7:0]  a, b;
    logic [15:0] out;
    logic        in_valid1, in_ready1, sm1, out_valid1, out_ready1;
    logic [15:0] a1, b1;
    logic [31:0] out1;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mult_pipelined_param #(.DATA_WIDTH(8), .PIPE_STAGES(3)) u0 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (sm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out)
    );

    mult_pipelined_param #(.DATA_WIDTH(16), .PIPE_STAGES(1)) u1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid1),
        .in_ready    (in_ready1),
        .a           (a1),
        .b           (b1),
        .signed_mode (sm1),
        .out_valid   (out_valid1),
        .out_ready   (out_ready1),
        .out         (out1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] model8(input logic [7:0] x,
                                           input logic [7:0] y,
                                           input logic s);
        longint xx, yy;
        xx = s ? {{56{x[7]}}, x} : {56'd0, x};
        yy = s ? {{56{y[7]}}, y} : {56'd0, y};
        return 16'(xx * yy);
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec8_t       tv[$];
        vec16_t      tw[$];
        logic [15:0] q[$];
        logic [15:0] held, prev_out;
        int          sent, got, stall, n;
        bit          stalled, prev_stall;

        tv.push_back('{8'h80, 8'h80, 1'b1, 16'h4000});
        tv.push_back('{8'hFF, 8'h02, 1'b1, 16'hFFFE});
        tv.push_back('{8'hFF, 8'hFF, 1'b0, 16'hFE01});
        tv.push_back('{8'hFF, 8'hFF, 1'b1, 16'h0001});
        tv.push_back('{8'h7F, 8'h80, 1'b1, 16'hC080});
        tv.push_back('{8'h80, 8'h80, 1'b0, 16'h4000});
        tv.push_back('{8'h80, 8'hFF, 1'b1, 16'h0080});
        tv.push_back('{8'h80, 8'h7F, 1'b0, 16'h3F80});
        tv.push_back('{8'h12, 8'h34, 1'b0, 16'h03A8});
        tv.push_back('{8'hFF, 8'h01, 1'b0, 16'h00FF});
        tv.push_back('{8'hFF, 8'h01, 1'b1, 16'hFFFF});
        tv.push_back('{8'h00, 8'hFF, 1'b1, 16'h0000});

        tw.push_back('{16'h8000, 16'h8000, 1'b1, 32'h4000_0000});
        tw.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001});
        tw.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001});
        tw.push_back('{16'h1234, 16'h5678, 1'b0, 32'h0626_0060});
        tw.push_back('{16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000});

        rst = 1'b1;
        in_valid = 0; a = 0; b = 0; sm = 0; out_ready = 0;
        in_valid1 = 0; a1 = 0; b1 = 0; sm1 = 0; out_ready1 = 0;
        repeat (2) tick;
        chk("reset out_valid", out_valid, 0);
        chk("reset out", out, 0);
        chk("reset out_valid1", out_valid1, 0);
        chk("reset out1", out1, 0);
        rst = 1'b0;
        #1;
        chk("in_ready after reset", in_ready, 1);

        // basic latency: accepted in cycle 0, visible in cycle 3 only
        out_ready = 1; in_valid = 1; a = 3; b = 5; sm = 0;
        tick;
        in_valid = 0;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("latency valid c%0d", k), out_valid, (k == 3));
            if (k == 3) chk("latency out", out, 15);
            tick;
        end

        // table vectors, back to back
        n = tv.size();
        for (int k = 0; k < n + 2; k++) begin
            if (k < n) begin
                in_valid = 1; a = tv[k].a; b = tv[k].b; sm = tv[k].s;
            end else begin
                in_valid = 0;
            end
            tick;
            if (k >= 2) begin
                chk($sformatf("vec%0d valid", k - 2), out_valid, 1);
                chk($sformatf("vec%0d out", k - 2), out, tv[k-2].p);
            end
        end
        in_valid = 0;
        repeat (3) tick;

        // backpressure: 1x1..6x1 with a 4-cycle stall
        sent = 0; got = 0; stall = 0; stalled = 0; held = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (!stalled && out_valid) begin
                stalled = 1; stall = 4; held = out;
            end
            out_ready = (stall == 0);
            in_valid = (sent < 6); a = 8'(sent + 1); b = 1; sm = 0;
            #1;
            if (stall > 0) begin
                chk("bp in_ready low", in_ready, 0);
                chk("bp out_valid held", out_valid, 1);
                chk("bp out held", out, held);
                stall--;
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                chk($sformatf("bp result %0d", got + 1), out, got + 1);
                got++;
            end
            tick;
        end
        chk("bp results count", got, 6);
        in_valid = 0; out_ready = 1;
        repeat (4) tick;

        // reset mid-stream while stalled, with a valid input on the edge
        for (int k = 0; k < 3; k++) begin
            in_valid = 1; a = 8'(k + 9); b = 2; sm = 0;
            tick;
        end
        chk("pre-rst out_valid", out_valid, 1);
        out_ready = 0; in_valid = 1; a = 8'h55; b = 1; rst = 1;
        tick;
        chk("rst out_valid", out_valid, 0);
        chk("rst out", out, 0);
        rst = 0; in_valid = 0; out_ready = 1;
        #1;
        chk("in_ready after rst pulse", in_ready, 1);
        for (int k = 0; k < 6; k++) begin
            tick;
            chk($sformatf("no stale c%0d", k), out_valid, 0);
        end

        // random mixed traffic against the reference model
        sent = 0; prev_stall = 0; prev_out = 0;
        for (int c = 0; c < 1500; c++) begin
            in_valid = (sent < 300) && ($urandom_range(0, 3) != 0);
            a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom);
            out_ready = (sent >= 300) || ($urandom_range(0, 3) != 0);
            #1;
            if (prev_stall) begin
                chk("rand hold valid", out_valid, 1);
                chk("rand hold out", out, prev_out);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("rand spurious", out_valid, 0);
                else chk("rand result", out, q.pop_front());
            end
            if (in_valid && in_ready) begin
                q.push_back(model8(a, b, sm));
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out = out;
            tick;
        end
        chk("rand sent", sent, 300);
        chk("rand drained", q.size(), 0);
        in_valid = 0;

        // single-stage 16-bit build
        out_ready1 = 1;
        for (int k = 0; k < tw.size(); k++) begin
            in_valid1 = 1; a1 = tw[k].a; b1 = tw[k].b; sm1 = tw[k].s;
            tick;
            chk($sformatf("w16 vec%0d valid", k), out_valid1, 1);
            chk($sformatf("w16 vec%0d out", k), out1, tw[k].p);
        end
        out_ready1 = 0; in_valid1 = 1; a1 = 2; b1 = 3; sm1 = 0;
        #1;
        chk("w16 stall in_ready", in_ready1, 0);
        tick;
        chk("w16 stall out", out1, 32'hC000_8000);
        out_ready1 = 1;
        #1;
        chk("w16 resume in_ready", in_ready1, 1);
        tick;
        chk("w16 resume out", out1, 6);
        in_valid1 = 0;
        tick;
        chk("w16 idle valid", out_valid1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
